// File: rtl/approx_mul_err_monitor_if.sv
// Beat stream between the approximate multiplier and its error monitor.
//   in_valid  : operand/product beat valid (producer -> monitor)
//   in_ready  : monitor accepts a beat this cycle (monitor -> producer)
//   a, b      : 8-bit multiplier operands
//   prod_apx  : 16-bit approximate product under test
// master = producer side, slave = monitor side.
interface approx_mul_err_monitor_if;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [15:0] prod_apx;

  modport master (output in_valid, a, b, prod_apx, input in_ready);
  modport slave  (input in_valid, a, b, prod_apx, output in_ready);
endinterface

// File: rtl/approx_mul_err_monitor.sv
// Error-metric accumulator for an 8x8 approximate multiplier.
// For each accepted beat the exact product is recomputed, the error distance
// ED = |exact - approx| is derived, and over a programmed run length the block
// accumulates the error count, the ED sum and the maximum ED together with the
// operands that first produced it.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   start         : one-cycle run request, honoured only when idle
//   num_samples   : run length, captured with an accepted start
//   beat          : operand/product stream (slave side of the interface)
//   busy          : run in progress
//   done          : one-cycle pulse, statistics final and stable
//   err_cnt       : samples with ED != 0 (saturating)
//   ed_sum        : sum of ED (saturating)
//   ed_max        : largest ED seen
//   max_a, max_b  : operands of the first sample reaching ed_max
module approx_mul_err_monitor #(
  parameter int unsigned CNT_W = 17,
  parameter int unsigned SUM_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [CNT_W-1:0]         num_samples,
  approx_mul_err_monitor_if.slave  beat,
  output logic                     busy,
  output logic                     done,
  output logic [CNT_W-1:0]         err_cnt,
  output logic [SUM_W-1:0]         ed_sum,
  output logic [15:0]              ed_max,
  output logic [7:0]               max_a,
  output logic [7:0]               max_b
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] remaining, remaining_nxt;
  logic             done_nxt;
  logic             clr_stats;
  logic             accept;

  // Pipeline: beats land in a capture register on the accepting edge, then
  // pass S1 (exact product), S2 (error distance) and S3 (accumulators).
  // This puts the statistics update three edges after acceptance.
  logic        p0_vld, p1_vld, p2_vld;
  logic [7:0]  p0_a, p0_b, p1_a, p1_b, p2_a, p2_b;
  logic [15:0] p0_apx, p1_apx, p1_exact, p2_ed;
  logic        p2_nz;

  logic [SUM_W:0] sum_ext;

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      remaining <= '0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      remaining <= remaining_nxt;
      done      <= done_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    remaining_nxt = remaining;
    done_nxt      = 1'b0;
    clr_stats     = 1'b0;
    accept        = 1'b0;
    beat.in_ready = 1'b0;
    busy          = (state != IDLE);
    case (state)
      IDLE: begin
        if (start) begin
          clr_stats     = 1'b1;
          remaining_nxt = num_samples;
          if (num_samples == '0) done_nxt  = 1'b1;
          else                   state_nxt = RUN;
        end
      end
      RUN: begin
        beat.in_ready = 1'b1;
        accept        = beat.in_valid;
        if (accept) begin
          remaining_nxt = remaining - CNT_W'(1);
          if (remaining == CNT_W'(1)) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        // No new beats enter in DRAIN, so the last beat is the one alone in S2.
        if (p2_vld && !p1_vld && !p0_vld) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------- pipeline ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      p0_vld <= 1'b0;
      p1_vld <= 1'b0;
      p2_vld <= 1'b0;
    end else begin
      p0_vld <= accept;
      p1_vld <= p0_vld;
      p2_vld <= p1_vld;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      p0_a   <= beat.a;
      p0_b   <= beat.b;
      p0_apx <= beat.prod_apx;
    end
    p1_a     <= p0_a;
    p1_b     <= p0_b;
    p1_apx   <= p0_apx;
    p1_exact <= 16'(p0_a) * 16'(p0_b);
    p2_a     <= p1_a;
    p2_b     <= p1_b;
    p2_ed    <= (p1_exact >= p1_apx) ? (p1_exact - p1_apx) : (p1_apx - p1_exact);
    p2_nz    <= (p1_exact != p1_apx);
  end

  // ---------------- accumulators ----------------
  always_comb begin
    sum_ext = {1'b0, ed_sum} + (SUM_W+1)'(p2_ed);
  end

  always_ff @(posedge clk) begin
    if (rst || clr_stats) begin
      err_cnt <= '0;
      ed_sum  <= '0;
      ed_max  <= '0;
      max_a   <= '0;
      max_b   <= '0;
    end else if (p2_vld) begin
      if (p2_nz && (err_cnt != '1)) err_cnt <= err_cnt + CNT_W'(1);
      ed_sum <= sum_ext[SUM_W] ? '1 : sum_ext[SUM_W-1:0];
      // Strictly greater: ties keep the earlier sample's operands.
      if (p2_ed > ed_max) begin
        ed_max <= p2_ed;
        max_a  <= p2_a;
        max_b  <= p2_b;
      end
    end
  end

endmodule

// File: tb/tb_approx_mul_err_monitor.sv
// Bench for approx_mul_err_monitor: table-driven single-beat runs, hand-written
// multi-cycle sequences and randomized runs against a behavioural model.
// A second instance with a narrow ed_sum exercises saturation.
module tb_approx_mul_err_monitor;
  localparam int unsigned CNT_W = 17;
  localparam int unsigned SUM_W = 32;
  localparam int unsigned SAT_W = 17;
  localparam longint unsigned SAT_MAX = (64'd1 << SAT_W) - 1;

  logic clk = 1'b0;
  logic rst, start;
  logic [CNT_W-1:0] num_samples;

  logic             busy, done;
  logic [CNT_W-1:0] err_cnt;
  logic [SUM_W-1:0] ed_sum;
  logic [15:0]      ed_max;
  logic [7:0]       max_a, max_b;

  logic             busy2, done2;
  logic [CNT_W-1:0] err_cnt2;
  logic [SAT_W-1:0] ed_sum2;
  logic [15:0]      ed_max2;
  logic [7:0]       max_a2, max_b2;

  approx_mul_err_monitor_if bif ();
  approx_mul_err_monitor_if bif2 ();

  assign bif2.in_valid = bif.in_valid;
  assign bif2.a        = bif.a;
  assign bif2.b        = bif.b;
  assign bif2.prod_apx = bif.prod_apx;

  approx_mul_err_monitor #(.CNT_W(CNT_W), .SUM_W(SUM_W)) dut (
    .clk(clk), .rst(rst), .start(start), .num_samples(num_samples), .beat(bif),
    .busy(busy), .done(done), .err_cnt(err_cnt), .ed_sum(ed_sum),
    .ed_max(ed_max), .max_a(max_a), .max_b(max_b)
  );

  approx_mul_err_monitor #(.CNT_W(CNT_W), .SUM_W(SAT_W)) dut_sat (
    .clk(clk), .rst(rst), .start(start), .num_samples(num_samples), .beat(bif2),
    .busy(busy2), .done(done2), .err_cnt(err_cnt2), .ed_sum(ed_sum2),
    .ed_max(ed_max2), .max_a(max_a2), .max_b(max_b2)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  int qa[$];
  int qb[$];
  int qp[$];

  typedef struct {
    int a;
    int b;
    int apx;
    int exp_err;
    int exp_sum;
    int exp_max;
    int exp_ma;
    int exp_mb;
  } vec_t;

  vec_t tbl[7];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Behavioural reference: statistics of the beats in qa/qb/qp.
  task automatic check_model(input string tag);
    longint unsigned e, s, m, ma, mb, ex, ed;
    e = 0; s = 0; m = 0; ma = 0; mb = 0;
    for (int i = 0; i < qa.size(); i++) begin
      ex = longint'(qa[i]) * longint'(qb[i]);
      ed = (ex >= longint'(qp[i])) ? ex - longint'(qp[i]) : longint'(qp[i]) - ex;
      if (ed != 0) e++;
      s += ed;
      if (ed > m) begin
        m = ed; ma = longint'(qa[i]); mb = longint'(qb[i]);
      end
    end
    chk({tag, ".err_cnt"}, 64'(err_cnt), e);
    chk({tag, ".ed_sum"},  64'(ed_sum),  s);
    chk({tag, ".ed_max"},  64'(ed_max),  m);
    chk({tag, ".max_a"},   64'(max_a),   ma);
    chk({tag, ".max_b"},   64'(max_b),   mb);
    chk({tag, ".sat_sum"}, 64'(ed_sum2), (s > SAT_MAX) ? SAT_MAX : s);
  endtask

  // Runs one sample run of n beats from qa/qb/qp.
  // mode 0: continuous valid, 1: valid on odd cycles, 2: random valid.
  task automatic run(input int n, input int mode, input bit mid_start,
                     input bit use_model, input string tag);
    int  cyc, acc_cnt, ready_late;
    bit  seen, v, acc;
    num_samples  = CNT_W'(n);
    start        = 1'b1;
    bif.in_valid = 1'b0;
    tick;
    start      = 1'b0;
    cyc        = 1;
    acc_cnt    = 0;
    ready_late = 0;
    seen       = 1'b0;
    chk({tag, ".busy_rise"}, 64'(busy), 64'd1);
    while (!seen && cyc < 2000) begin
      if (done) begin
        seen = 1'b1;
      end else begin
        if (mode == 0)      v = 1'b1;
        else if (mode == 1) v = (cyc % 2 == 1);
        else                v = 1'($urandom_range(0, 1));
        if (acc_cnt < qa.size()) begin
          bif.a        = 8'(qa[acc_cnt]);
          bif.b        = 8'(qb[acc_cnt]);
          bif.prod_apx = 16'(qp[acc_cnt]);
        end else begin
          bif.a = 8'd255; bif.b = 8'd255; bif.prod_apx = 16'd0;
          if (bif.in_ready) ready_late++;
        end
        bif.in_valid = v;
        if (mid_start && cyc == 3) begin
          start = 1'b1; num_samples = CNT_W'(1);
        end
        acc = v && bif.in_ready;
        if (acc) acc_cnt++;
        tick;
        start = 1'b0;
        cyc++;
      end
    end
    bif.in_valid = 1'b0;
    chk({tag, ".done_seen"}, 64'(seen), 64'd1);
    chk({tag, ".accepted"}, 64'(acc_cnt), 64'(n));
    chk({tag, ".ready_after_last"}, 64'(ready_late), 64'd0);
    if (seen) begin
      if (mode == 0) chk({tag, ".done_cycle"}, 64'(cyc), 64'(n + 4));
      if (mode == 1) chk({tag, ".done_cycle"}, 64'(cyc), 64'(2 * n + 3));
      chk({tag, ".busy_at_done"}, 64'(busy), 64'd0);
      chk({tag, ".sat_done"}, 64'(done2), 64'd1);
      if (use_model) check_model(tag);
      tick;
      chk({tag, ".done_pulse"}, 64'(done), 64'd0);
    end
  endtask

  task automatic load1(input int a, input int b, input int p);
    qa.push_back(a); qb.push_back(b); qp.push_back(p);
  endtask

  task automatic clear_q;
    qa.delete(); qb.delete(); qp.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, dn, r, x, p, a, b;

    tbl[0] = '{3,   5,   15,    0, 0,     0,     0,   0};
    tbl[1] = '{255, 255, 0,     1, 65025, 65025, 255, 255};
    tbl[2] = '{0,   0,   65535, 1, 65535, 65535, 0,   0};
    tbl[3] = '{16,  16,  200,   1, 56,    56,    16,  16};
    tbl[4] = '{7,   9,   100,   1, 37,    37,    7,   9};
    tbl[5] = '{200, 100, 20000, 0, 0,     0,     0,   0};
    tbl[6] = '{1,   255, 0,     1, 255,   255,   1,   255};

    rst = 1'b1; start = 1'b0; num_samples = '0;
    bif.in_valid = 1'b0; bif.a = '0; bif.b = '0; bif.prod_apx = '0;
    tick; tick;
    rst = 1'b0;
    chk("reset.in_ready", 64'(bif.in_ready), 64'd0);
    chk("reset.busy",     64'(busy),         64'd0);
    chk("reset.done",     64'(done),         64'd0);
    chk("reset.err_cnt",  64'(err_cnt),      64'd0);
    chk("reset.ed_sum",   64'(ed_sum),       64'd0);
    chk("reset.ed_max",   64'(ed_max),       64'd0);
    chk("reset.max_ab",   64'({max_a, max_b}), 64'd0);
    tick;

    // Exact products: no error.
    clear_q;
    load1(3, 5, 15); load1(255, 255, 65025); load1(12, 11, 132); load1(0, 77, 0);
    run(4, 0, 1'b0, 1'b0, "exact4");
    chk("exact4.err_cnt", 64'(err_cnt), 64'd0);
    chk("exact4.ed_sum",  64'(ed_sum),  64'd0);
    chk("exact4.ed_max",  64'(ed_max),  64'd0);

    // Table of single-beat runs.
    for (int i = 0; i < 7; i++) begin
      clear_q;
      load1(tbl[i].a, tbl[i].b, tbl[i].apx);
      run(1, 0, 1'b0, 1'b0, $sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d.err_cnt", i), 64'(err_cnt), 64'(tbl[i].exp_err));
      chk($sformatf("tbl%0d.ed_sum", i),  64'(ed_sum),  64'(tbl[i].exp_sum));
      chk($sformatf("tbl%0d.ed_max", i),  64'(ed_max),  64'(tbl[i].exp_max));
      chk($sformatf("tbl%0d.max_a", i),   64'(max_a),   64'(tbl[i].exp_ma));
      chk($sformatf("tbl%0d.max_b", i),   64'(max_b),   64'(tbl[i].exp_mb));
    end

    // Mixed errors.
    clear_q;
    load1(255, 255, 0); load1(2, 2, 5); load1(10, 10, 100);
    run(3, 0, 1'b0, 1'b0, "mix3");
    chk("mix3.err_cnt", 64'(err_cnt), 64'd2);
    chk("mix3.ed_sum",  64'(ed_sum),  64'd65026);
    chk("mix3.ed_max",  64'(ed_max),  64'd65025);
    chk("mix3.max_a",   64'(max_a),   64'd255);
    chk("mix3.max_b",   64'(max_b),   64'd255);

    // Tie keeps the earlier sample.
    clear_q;
    load1(4, 4, 14); load1(2, 8, 18);
    run(2, 0, 1'b0, 1'b0, "tie");
    chk("tie.ed_max", 64'(ed_max), 64'd2);
    chk("tie.max_a",  64'(max_a),  64'd4);
    chk("tie.max_b",  64'(max_b),  64'd4);
    chk("tie.ed_sum", 64'(ed_sum), 64'd4);

    // Gapped valid with an ignored start mid-run.
    clear_q;
    load1(17, 3, 60); load1(100, 200, 0); load1(9, 9, 81); load1(50, 2, 120); load1(255, 1, 250);
    run(5, 1, 1'b1, 1'b1, "gap5");

    // N=0: immediate done, statistics cleared, nothing accepted.
    bif.in_valid = 1'b1; bif.a = 8'd255; bif.b = 8'd255; bif.prod_apx = 16'd0;
    num_samples = '0; start = 1'b1;
    chk("n0.in_ready_idle", 64'(bif.in_ready), 64'd0);
    tick;
    start = 1'b0;
    chk("n0.done",     64'(done),         64'd1);
    chk("n0.busy",     64'(busy),         64'd0);
    chk("n0.in_ready", 64'(bif.in_ready), 64'd0);
    chk("n0.stats",    64'({err_cnt, ed_max, max_a, max_b}), 64'd0);
    chk("n0.ed_sum",   64'(ed_sum),       64'd0);
    tick;
    chk("n0.done_pulse", 64'(done), 64'd0);
    tick; tick; tick; tick;
    bif.in_valid = 1'b0;
    chk("n0.no_leak", 64'(ed_sum), 64'd0);

    // Leave nonzero stats, then abort an N=10 run with reset.
    clear_q;
    load1(255, 255, 0);
    run(1, 0, 1'b0, 1'b0, "pre_rst");
    num_samples = CNT_W'(10); start = 1'b1;
    tick;
    start = 1'b0;
    bif.in_valid = 1'b1; bif.a = 8'd255; bif.b = 8'd255; bif.prod_apx = 16'd0;
    tick; tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("abort.busy",     64'(busy),         64'd0);
    chk("abort.done",     64'(done),         64'd0);
    chk("abort.in_ready", 64'(bif.in_ready), 64'd0);
    chk("abort.err_cnt",  64'(err_cnt),      64'd0);
    chk("abort.ed_sum",   64'(ed_sum),       64'd0);
    chk("abort.ed_max",   64'(ed_max),       64'd0);
    dn = 0;
    for (int c = 0; c < 20; c++) begin
      if (done) dn++;
      tick;
    end
    bif.in_valid = 1'b0;
    chk("abort.no_done",  64'(dn),     64'd0);
    chk("abort.quiet",    64'(ed_sum), 64'd0);
    clear_q;
    load1(20, 30, 590);
    run(1, 0, 1'b0, 1'b1, "after_rst");

    // Randomized runs against the model.
    for (int k = 0; k < 25; k++) begin
      clear_q;
      n = int'($urandom_range(1, 40));
      for (int i = 0; i < n; i++) begin
        a = int'($urandom_range(0, 255));
        b = int'($urandom_range(0, 255));
        x = a * b;
        r = int'($urandom_range(0, 3));
        if (r == 0)      p = x;
        else if (r == 1) p = (x + int'($urandom_range(0, 8)) > 65535) ? 65535 : x + int'($urandom_range(0, 8));
        else if (r == 2) p = int'($urandom_range(0, 65535));
        else             p = 0;
        load1(a, b, p);
      end
      run(n, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), 1'b1,
          $sformatf("rnd%0d", k));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/approx_mul_err_monitor.md
# approx_mul_err_monitor

Pipelined error-metric accumulator placed directly downstream of the 8x8 approximate multiplier `ac_1233`. For each accepted beat it takes the operands `a`, `b` and the approximate product `prod8`, recomputes the exact product internally and derives the error distance ED = |exact − approx|. Over a run of a programmed number of samples it accumulates the error count, the ED sum and the maximum ED with the operands that produced it. A full exhaustive sweep of 65536 operand pairs characterises one multiplier configuration in hardware.

## Interface
- CNT_W, 17: width of the sample counter and `err_cnt`; up to 2^CNT_W − 1 samples per run.
- SUM_W, 32: width of `ed_sum`; 32 is enough for 65536 × 65025.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle run request; accepted only in IDLE.
- num_samples  in  CNT_W  run length, sampled on an accepted `start`.
- in_valid  in  1  operand/product beat valid.
- in_ready  out  1  block accepts a beat this cycle.
- a, b  in  8 each  multiplier operands.
- prod_apx  in  16  approximate product (`prod8` of `ac_1233`).
- busy  out  1  run in progress (RUN or DRAIN).
- done  out  1  one-cycle pulse when the run's statistics are final.
- err_cnt  out  CNT_W  number of samples with ED ≠ 0.
- ed_sum  out  SUM_W  sum of ED over the run.
- ed_max  out  16  largest ED seen.
- max_a, max_b  out  8 each  operands of the first sample reaching `ed_max`.

## Operation
- FSM states: IDLE, RUN, DRAIN.
- IDLE:
  - `in_ready` = 0; statistics outputs hold their last values.
  - `start`=1 clears all statistics to 0 and loads `remaining` = `num_samples`.
  - If `num_samples` = 0: stay in IDLE and pulse `done` on the next cycle.
  - Otherwise go to RUN.
- RUN:
  - `in_ready` = 1.
  - A beat is accepted when `in_valid` & `in_ready`; each accepted beat decrements `remaining`.
  - The edge that accepts the beat leaving `remaining` = 0 moves the FSM to DRAIN. `in_ready` is 0 from that point.
  - `in_valid` gaps are allowed; the FSM waits indefinitely.
- DRAIN:
  - Waits until the three pipeline stages are empty.
  - On the edge that accumulates the last beat it returns to IDLE and asserts `done` for exactly one cycle.
- `start` while `busy` = 1 is ignored.
- Pipeline:
  - S1 registers a, b, prod_apx, and exact = a*b (16-bit unsigned, no truncation).
  - S2 registers ED = (exact ≥ apx) ? exact − apx : apx − exact (16 bits), plus nz = (ED ≠ 0), plus a and b.
  - S3 accumulates:
    - `err_cnt` += nz.
    - `ed_sum` += ED, zero-extended.
    - If ED > `ed_max` (strictly greater), `ed_max`, `max_a` and `max_b` are updated. Ties keep the earlier sample.
- Overflow: `ed_sum` and `err_cnt` saturate at all-ones, never wrap.
- `prod_apx` is not range-checked; any 16-bit value is legal.

## Timing
- Reset values: `in_ready`, `busy`, `done` = 0; all statistics = 0; FSM in IDLE; pipeline valid bits cleared.
- `rst` mid-run aborts the run: no `done` pulse, and statistics are cleared.
- `busy` rises on the edge after an accepted `start` and falls on the same edge `done` rises.
- Latency: a beat accepted at edge k is reflected in the statistics after edge k+3.
  - For the last beat, `done` is high in the cycle following edge k+3, so statistics are valid and stable whenever `done` = 1.
- Throughput: one beat per cycle with continuous `in_valid`.
- Minimum run of N beats: N + 4 cycles from `start` to `done`.
- `in_ready` is registered, not combinationally dependent on `in_valid`.

## Test plan
- Reset, then `start` with N=4, beats with prod_apx = a*b exactly (e.g. 3×5=15, 255×255=65025) → `done` at cycle 8; err_cnt=0, ed_sum=0, ed_max=0.
- N=3, beats (255,255,apx 0), (2,2,apx 5), (10,10,apx 100) → err_cnt=2, ed_sum=65026, ed_max=65025, max_a=255, max_b=255.
- Tie check: N=2, (4,4,apx 14), (2,8,apx 18), both ED=2 → ed_max=2, max_a=4, max_b=4.
- `in_valid` toggling every other cycle, N=5 → exactly 5 beats accepted, `in_ready` low after the 5th, single `done` pulse; a `start` pulsed mid-run has no effect.
- N=0 → no beats accepted, `done` pulse one cycle after `start`, all statistics 0.
- `rst` asserted two cycles into an N=10 run → all outputs at reset values, no `done`; a fresh N=1 run then completes normally.
